bt_status_tx: RTL and testbench

//  UART 8N1 transmitter on the Bluetooth module's RX pin; reverse direction of the existing Bluetooth receiver.
//  On a one-cycle send pulse, latches game mode and score and emits a 9-byte ASCII status frame to the phone:
//  "M<m>S<d3><d2><d1><d0>\r\n". Pianogame pulses send on every State change and on game over.

---
 rtl/bt_status_tx_pkg.sv | 34 +++
 rtl/bt_status_tx_bin2bcd_11.sv | 49 ++++
 rtl/bt_status_tx.sv | 104 ++++++++++
 tb/tb_bt_status_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/bt_status_tx_pkg.sv
// bt_status_tx_pkg: shared Bluetooth UART definitions (baud constant, ASCII codes, frame length, FSM states, byte table)
package bt_status_tx_pkg;

    localparam int CLKS_PER_BIT_DEF = 10417;
    localparam int FRAME_LEN        = 9;

    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_Q  = 8'h3F;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CONV  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } state_t;

    // ASCII digit for 0..9 is simply 0x3 in the upper nibble
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [3:0] m, input logic [15:0] bcd);
        return idx == 4'd0 ? CH_M :
               idx == 4'd1 ? (m <= 4'd9 ? (CH_0 | {4'd0, m}) : CH_Q) :
               idx == 4'd2 ? CH_S :
               idx == 4'd3 ? (CH_0 | {4'd0, bcd[15:12]}) :
               idx == 4'd4 ? (CH_0 | {4'd0, bcd[11:8]}) :
               idx == 4'd5 ? (CH_0 | {4'd0, bcd[7:4]}) :
               idx == 4'd6 ? (CH_0 | {4'd0, bcd[3:0]}) :
               idx == 4'd7 ? CH_CR : CH_LF;
    endfunction

endpackage

// File: rtl/bt_status_tx_bin2bcd_11.sv
// bin2bcd_11: iterative 11-cycle double-dabble, 11-bit binary to 4 BCD digits
//  CLK, RST : clock, asynchronous active-high reset
//  start    : load bin and begin conversion
//  bin      : binary value 0..2047
//  ready    : high when no conversion is running (bcd valid after a conversion)
//  bcd      : {thousands, hundreds, tens, units}
module bin2bcd_11 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        start,
    input  logic [10:0] bin,
    output logic        ready,
    output logic [15:0] bcd
);

    logic [10:0] sr;
    logic [3:0]  cnt;
    logic        run;
    logic [11:0] adj;

    // Thousands digit never exceeds 1 before a shift for 11-bit inputs, so only the lower three get add-3
    always_comb begin
        adj = bcd[11:0];
        for (int i = 0; i < 3; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sr  <= '0;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b0;
        end else if (start) begin
            sr  <= bin;
            bcd <= '0;
            cnt <= '0;
            run <= 1'b1;
        end else if (run) begin
            bcd <= {bcd[14:12], adj, sr[10]};
            sr  <= {sr[9:0], 1'b0};
            cnt <= cnt + 4'd1;
            run <= cnt != 4'd10;
        end
    end

    assign ready = !run;

endmodule

// File: rtl/bt_status_tx.sv
// bt_status_tx: UART 8N1 transmitter sending "M<m>S<dddd>\r\n" status frames to the Bluetooth module
//  CLK, RST : 100 MHz clock, asynchronous active-high reset
//  send     : request pulse, accepted only when idle
//  mode     : game state to report (shown as '?' above 9)
//  score    : binary score 0..2047
//  txd      : registered serial line, idle high
//  busy     : high from acceptance until the last stop bit ends
//  done     : one-cycle pulse after the last stop bit
module bt_status_tx
    import bt_status_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        send,
    input  logic [3:0]  mode,
    input  logic [10:0] score,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    state_t          state, state_n;
    logic [3:0]      mode_r, byte_idx, byte_n;
    logic [2:0]      bit_idx, bit_n;
    logic [BW-1:0]   baud, baud_n;
    logic            txd_n, done_n, wrap, accept, bcd_ready;
    logic [15:0]     bcd;
    logic [7:0]      tx_byte;

    assign accept  = send && state == ST_IDLE;
    assign wrap    = baud == BW'(CLKS_PER_BIT - 1);
    assign tx_byte = frame_byte(byte_idx, mode_r, bcd);
    assign busy    = state != ST_IDLE;

    bin2bcd_11 u_bcd (
        .CLK   (CLK),
        .RST   (RST),
        .start (accept),
        .bin   (score),
        .ready (bcd_ready),
        .bcd   (bcd)
    );

    always_comb begin
        state_n = state;
        byte_n  = byte_idx;
        bit_n   = bit_idx;
        txd_n   = txd;
        done_n  = 1'b0;
        case (state)
            ST_IDLE:  if (send) begin
                          state_n = ST_CONV;
                          byte_n  = '0;
                      end
            ST_CONV:  if (bcd_ready) begin
                          state_n = ST_START;
                          txd_n   = 1'b0;
                      end
            ST_START: if (wrap) begin
                          state_n = ST_DATA;
                          bit_n   = '0;
                          txd_n   = tx_byte[0];
                      end
            ST_DATA:  if (wrap) begin
                          state_n = bit_idx == 3'd7 ? ST_STOP : ST_DATA;
                          bit_n   = bit_idx + 3'd1;
                          txd_n   = bit_idx == 3'd7 ? 1'b1 : tx_byte[bit_idx + 3'd1];
                      end
            ST_STOP:  if (wrap) begin
                          state_n = byte_idx == 4'(FRAME_LEN - 1) ? ST_IDLE : ST_START;
                          done_n  = byte_idx == 4'(FRAME_LEN - 1);
                          byte_n  = byte_idx + 4'd1;
                          txd_n   = byte_idx == 4'(FRAME_LEN - 1);
                      end
            default:  state_n = ST_IDLE;
        endcase
        baud_n = (state == ST_START || state == ST_DATA || state == ST_STOP) && !wrap ? baud + BW'(1) : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ST_IDLE;
            mode_r   <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            txd      <= 1'b1;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_r   <= accept ? mode : mode_r;
            byte_idx <= byte_n;
            bit_idx  <= bit_n;
            baud     <= baud_n;
            txd      <= txd_n;
            done     <= done_n;
        end
    end

endmodule

// File: tb/tb_bt_status_tx.sv
// tb_bt_status_tx: directed self-checking bench for bt_status_tx with an 8N1 mid-bit decoder
module tb_bt_status_tx;

    localparam int CPB = 8;

    logic        CLK = 1'b0, RST = 1'b1, send = 1'b0;
    logic        RST2 = 1'b1, send2 = 1'b0;
    logic [3:0]  mode = '0;
    logic [10:0] score = '0;
    logic        txd, busy, done, txd2, busy2, done2;
    int          total = 0, bad = 0, cyc = 0, done_cnt = 0;
    int          a, a2, d, n0, t, s;

    always #5 CLK = ~CLK;

    bt_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK(CLK), .RST(RST), .send(send), .mode(mode), .score(score),
        .txd(txd), .busy(busy), .done(done)
    );

    bt_status_tx u_slow (
        .CLK(CLK), .RST(RST2), .send(send2), .mode(mode), .score(score),
        .txd(txd2), .busy(busy2), .done(done2)
    );

    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) if (done) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns the cycle number of the accepting edge
    task automatic pulse(input logic [3:0] m, input logic [10:0] sc, output int acc);
        mode  = m;
        score = sc;
        send  = 1'b1;
        @(negedge CLK);
        acc  = cyc;
        send = 1'b0;
        chk("busy_acc", {31'd0, busy}, 1);
    endtask

    task automatic rx_frame(input string tag, input logic [0:8][7:0] e, input int acc);
        int w;
        logic [7:0] b;
        logic ok;
        ok = 1'b1;
        for (int j = 0; j < 9; j++) begin
            w = 0;
            while (txd !== 1'b0 && w < 100) begin
                @(negedge CLK);
                w++;
            end
            if (txd !== 1'b0) begin
                chk({tag, "_start_timeout"}, 0, 1);
                return;
            end
            if (j == 0) chk({tag, "_start_cyc"}, cyc - acc, 12);
            repeat (CPB / 2) @(negedge CLK);
            ok &= txd === 1'b0 && busy === 1'b1;
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge CLK);
                b[k] = txd;
                ok &= busy === 1'b1;
            end
            chk($sformatf("%s_byte%0d", tag, j), {24'd0, b}, {24'd0, e[j]});
            repeat (CPB) @(negedge CLK);
            ok &= txd === 1'b1 && busy === 1'b1;
        end
        chk({tag, "_framing_busy"}, {31'd0, ok}, 1);
    endtask

    task automatic wait_done(input string tag, input int acc);
        int w;
        w = 0;
        while (done !== 1'b1 && w < 50) begin
            @(negedge CLK);
            w++;
        end
        chk({tag, "_done_cyc"}, done === 1'b1 ? cyc - acc : -1, 12 + 90 * CPB);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
        chk("rst_txd", {31'd0, txd}, 1);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        RST = 1'b0;
        @(negedge CLK);

        pulse(4'd2, 11'd1234, a);
        rx_frame("t1", {8'h4D, 8'h32, 8'h53, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, a);
        wait_done("t1", a);
        @(negedge CLK);
        chk("t1_done_width", {31'd0, done}, 0);
        chk("t1_idle", {31'd0, busy}, 0);

        repeat (3) @(negedge CLK);
        pulse(4'd0, 11'd2047, a);
        rx_frame("t2a", {8'h4D, 8'h30, 8'h53, 8'h32, 8'h30, 8'h34, 8'h37, 8'h0D, 8'h0A}, a);
        wait_done("t2a", a);

        repeat (3) @(negedge CLK);
        pulse(4'd1, 11'd0, a);
        rx_frame("t2b", {8'h4D, 8'h31, 8'h53, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}, a);
        wait_done("t2b", a);

        repeat (3) @(negedge CLK);
        pulse(4'd12, 11'd5, a);
        rx_frame("t3", {8'h4D, 8'h3F, 8'h53, 8'h30, 8'h30, 8'h30, 8'h35, 8'h0D, 8'h0A}, a);
        wait_done("t3", a);

        repeat (3) @(negedge CLK);
        n0 = done_cnt;
        pulse(4'd2, 11'd100, a);
        fork
            rx_frame("t4", {8'h4D, 8'h32, 8'h53, 8'h30, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A}, a);
            begin
                repeat (260) @(negedge CLK);
                mode  = 4'd5;
                score = 11'd999;
                send  = 1'b1;
                @(negedge CLK);
                send  = 1'b0;
            end
        join
        wait_done("t4", a);
        repeat (20) @(negedge CLK);
        chk("t4_one_done", done_cnt - n0, 1);
        chk("t4_idle", {31'd0, busy}, 0);

        n0 = done_cnt;
        pulse(4'd2, 11'd1234, a);
        repeat (342) @(negedge CLK);
        chk("t5_pre_txd", {31'd0, txd}, 0);
        RST = 1'b1;
        #1;
        chk("t5_rst_txd", {31'd0, txd}, 1);
        chk("t5_rst_busy", {31'd0, busy}, 0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (450) @(negedge CLK);
        chk("t5_no_done", done_cnt - n0, 0);
        chk("t5_line_idle", {31'd0, txd}, 1);
        pulse(4'd2, 11'd1234, a);
        rx_frame("t5b", {8'h4D, 8'h32, 8'h53, 8'h31, 8'h32, 8'h33, 8'h34, 8'h0D, 8'h0A}, a);
        wait_done("t5b", a);

        d = cyc;
        pulse(4'd1, 11'd7, a2);
        chk("t6_b2b_accept", a2 - d, 1);
        rx_frame("t6", {8'h4D, 8'h31, 8'h53, 8'h30, 8'h30, 8'h30, 8'h37, 8'h0D, 8'h0A}, a2);
        wait_done("t6", a2);

        RST2 = 1'b0;
        @(negedge CLK);
        send2 = 1'b1;
        @(negedge CLK);
        a = cyc;
        send2 = 1'b0;
        t = 0;
        while (txd2 !== 1'b0 && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("t6s_start_cyc", txd2 === 1'b0 ? cyc - a : -1, 12);
        s = cyc;
        t = 0;
        while (txd2 !== 1'b1 && t < 11000) begin
            @(negedge CLK);
            t++;
        end
        chk("t6s_bit_period", {31'd0, txd2 === 1'b1 && cyc - s >= 10416 && cyc - s <= 10418}, 1);
        RST2 = 1'b1;
        #1;
        chk("t6s_abort_txd", {31'd0, txd2}, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
